// File: rtl/mem_stage.sv
// DLX memory-access stage: big-endian byte/half/word loads and stores over a
// req/ack data-memory port. Optional access watchdog: MEM_TIMEOUT_EN.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [0:31] alu_in,
  input  logic [0:31] mem_data_in,
  input  logic        cond_in,
  input  logic [0:5]  op_in,
  input  logic [0:5]  fc_in,
  input  logic [0:4]  dreg_in,
  input  logic        stall_in,
  output logic [0:31] dmem_addr,
  output logic [0:31] dmem_wdata,
  output logic [0:3]  dmem_be,
  output logic        dmem_we,
  output logic        dmem_req,
  input  logic [0:31] dmem_rdata,
  input  logic        dmem_ack,
  output logic [0:31] wb_data,
  output logic [0:5]  op_out,
  output logic [0:5]  fc_out,
  output logic [0:4]  dreg_out,
  output logic        stall_out,
  output logic        branch_taken,
  output logic [0:31] branch_target,
  output logic        misalign,
  output logic        mem_busy,
  output logic        mem_fault
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam logic [0:5] OP_BEQZ = 6'b000100;
  localparam logic [0:5] OP_BNEZ = 6'b000101;
  localparam logic [0:5] OP_LB   = 6'b100000;
  localparam logic [0:5] OP_LH   = 6'b100001;
  localparam logic [0:5] OP_LBU  = 6'b100100;
  localparam logic [0:5] OP_LHU  = 6'b100101;
  localparam logic [0:5] OP_SB   = 6'b101000;
  localparam logic [0:5] OP_SH   = 6'b101001;

  logic [0:0]  state_q, state_d;
  logic [0:31] addr_q, addr_d;
  logic [0:31] wdata_q, wdata_d;
  logic [0:3]  be_q, be_d;
  logic        we_q, we_d;
  logic        req_q, req_d;
  logic [0:31] wb_q, wb_d;
  logic [0:5]  op_q, op_d;
  logic [0:5]  fc_q, fc_d;
  logic [0:4]  dreg_q, dreg_d;
  logic        stall_q, stall_d;
  logic        bt_q, bt_d;
  logic [0:31] btgt_q, btgt_d;
  logic        mis_q, mis_d;
  logic        fault_q, fault_d;
  logic [0:1]  off_q, off_d;
  logic [0:31] alu_q, alu_d;
`ifdef MEM_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
`endif

  logic [0:1]  off;
  logic        is_ld;
  logic        is_st;
  logic        is_mem;
  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic        is_br;
  logic        mis;
  logic [0:3]  be_n;
  logic [0:31] wd_n;
  logic [0:31] ld_fmt;

  assign off = alu_in[30:31];

  // Lane select and sign/zero extension of returned read data.
  function automatic logic [0:31] fmt_load(
    input logic [0:5]  op,
    input logic [0:1]  o,
    input logic [0:31] rd
  );
    logic [0:7]  b;
    logic [0:15] h;
    logic [0:31] r;
    case (o)
      2'd0:    b = rd[0:7];
      2'd1:    b = rd[8:15];
      2'd2:    b = rd[16:23];
      default: b = rd[24:31];
    endcase
    h = o[0] ? rd[16:31] : rd[0:15];
    unique case (1'b1)
      op == OP_LB:  r = {{24{b[0]}}, b};
      op == OP_LBU: r = {24'h000000, b};
      op == OP_LH:  r = {{16{h[0]}}, h};
      op == OP_LHU: r = {16'h0000, h};
      default:      r = rd;
    endcase
    return r;
  endfunction

  // Decode access size, alignment, byte enables and steered store data.
  always_comb begin
    is_ld  = op_in[0:2] == 3'b100;
    is_st  = op_in[0:2] == 3'b101;
    is_mem = is_ld | is_st;
    is_b   = (op_in == OP_LB) | (op_in == OP_LBU)
           | (op_in == OP_SB);
    is_h   = (op_in == OP_LH) | (op_in == OP_LHU)
           | (op_in == OP_SH);
    is_w   = ~(is_b | is_h);
    is_br  = (op_in == OP_BEQZ) | (op_in == OP_BNEZ);
    mis    = (is_h & off[1]) | (is_w & (off != 2'b00));
    be_n   = 4'b1111;
    wd_n   = mem_data_in;
    unique case (1'b1)
      is_b: begin
        be_n = 4'b1000 >> off;
        wd_n = {4{mem_data_in[24:31]}};
      end
      is_h: begin
        be_n = off[0] ? 4'b0011 : 4'b1100;
        wd_n = {2{mem_data_in[16:31]}};
      end
      default: begin
        be_n = 4'b1111;
        wd_n = mem_data_in;
      end
    endcase
  end

  assign ld_fmt = fmt_load(op_q, off_q, dmem_rdata);

  // Next-state logic for the IDLE/WAIT access sequencer and all outputs.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    req_d   = req_q;
    wb_d    = wb_q;
    op_d    = op_q;
    fc_d    = fc_q;
    dreg_d  = dreg_q;
    stall_d = stall_q;
    bt_d    = bt_q;
    btgt_d  = btgt_q;
    mis_d   = 1'b0;
    fault_d = 1'b0;
    off_d   = off_q;
    alu_d   = alu_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (stall_in) begin
          stall_d = 1'b1;
          bt_d    = 1'b0;
        end else if (is_mem && mis) begin
          mis_d   = 1'b1;
          stall_d = 1'b1;
          bt_d    = 1'b0;
        end else if (is_mem) begin
          state_d = WAIT;
          req_d   = 1'b1;
          we_d    = is_st;
          addr_d  = {alu_in[0:29], 2'b00};
          be_d    = be_n;
          wdata_d = wd_n;
          op_d    = op_in;
          fc_d    = fc_in;
          dreg_d  = dreg_in;
          off_d   = off;
          alu_d   = alu_in;
          stall_d = 1'b1;
          bt_d    = 1'b0;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end else begin
          wb_d    = alu_in;
          op_d    = op_in;
          fc_d    = fc_in;
          dreg_d  = dreg_in;
          stall_d = 1'b0;
          bt_d    = is_br & cond_in;
          if (is_br) btgt_d = alu_in;
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          stall_d = 1'b0;
          wb_d    = (op_q[0:2] == 3'b100) ? ld_fmt : alu_q;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q + 8'd1 == 8'(TIMEOUT)) begin
          state_d = IDLE;
          req_d   = 1'b0;
          we_d    = 1'b0;
          stall_d = 1'b1;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any outstanding request.
  always_ff @(negedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      req_q   <= 1'b0;
      wb_q    <= '0;
      op_q    <= '0;
      fc_q    <= '0;
      dreg_q  <= '0;
      stall_q <= 1'b1;
      bt_q    <= 1'b0;
      btgt_q  <= '0;
      mis_q   <= 1'b0;
      fault_q <= 1'b0;
      off_q   <= '0;
      alu_q   <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      req_q   <= req_d;
      wb_q    <= wb_d;
      op_q    <= op_d;
      fc_q    <= fc_d;
      dreg_q  <= dreg_d;
      stall_q <= stall_d;
      bt_q    <= bt_d;
      btgt_q  <= btgt_d;
      mis_q   <= mis_d;
      fault_q <= fault_d;
      off_q   <= off_d;
      alu_q   <= alu_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign dmem_be       = be_q;
  assign dmem_we       = we_q;
  assign dmem_req      = req_q;
  assign wb_data       = wb_q;
  assign op_out        = op_q;
  assign fc_out        = fc_q;
  assign dreg_out      = dreg_q;
  assign stall_out     = stall_q;
  assign branch_taken  = bt_q;
  assign branch_target = btgt_q;
  assign misalign      = mis_q;
  assign mem_busy      = (state_q == WAIT);

`ifdef MEM_TIMEOUT_EN
  assign mem_fault = fault_q;
`else
  logic [31:0] unused_tmo;
  logic        unused_flt;
  assign unused_tmo = TIMEOUT;
  assign unused_flt = fault_q;
  assign mem_fault  = 1'b0;
`endif

endmodule
